osc_bank: RTL and testbench
===========================

Name: osc_bank

Overview:
- Parametrised multi-voice divider oscillator.
- Successor to the single-voice 16-bit count/divider oscillator, generalised in:
  - counter width;
  - voice count;
  - glitch-free divider updates (shadow register);
  - per-voice wrap strobe and square-wave output.
- Sits between the note/keypad decode logic, which supplies the dividers, and the waveform/mixer stage, which consumes the counts, wraps and squares.

Parameters:
- WIDTH, 16, counter and divider width in bits (min 2).
- VOICES, 4, number of independent oscillator voices (min 1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  VOICES  per-voice enable; bit v controls voice v.
- divider  in  VOICES*WIDTH  requested period per voice; voice v in bits [v*WIDTH +: WIDTH].
- count  out  VOICES*WIDTH  per-voice phase count, same packing as divider.
- wrap  out  VOICES  one-cycle pulse per voice at period restart.
- square  out  VOICES  per-voice 50%-duty square wave.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high.
  - rst sampled high on a rising edge sets, for every v:
    - count[v] = 1;
    - active_div[v] = 0;
    - wrap[v] = 0.
  - Reset has priority over en and over all counting.
  - Reset mid-period discards the period; no wrap is emitted.
- Per voice v, each edge with rst low:
  - en[v]=0:
    - count = 1; wrap = 0;
    - active_div = divider[v], loaded immediately.
  - en[v]=1 and count >= active_div:
    - count = 1; wrap = 1;
    - active_div = divider[v], the new period taking effect from this point.
  - en[v]=1 and count < active_div:
    - count = count + 1; wrap = 0;
    - active_div holds.
- Divider changes while enabled are ignored until the next wrap, so a period is never truncated or stretched mid-cycle.
- Period:
  - With active_div = D >= 1, count sequence is 1,2,...,D,1; period D cycles; wrap high one cycle per period, in the same cycle count shows 1.
  - D = 0 or D = 1: count stays 1 and wrap is high every enabled cycle.
- Arithmetic:
  - Unsigned compare.
  - count can never exceed 2^WIDTH - 1, because count >= active_div forces restart first; no overflow path exists.
- Square output:
  - Combinational from registered state: square[v] = en[v] & (count[v] <= (active_div[v] >> 1)).
  - Value after reset: 0.
- Latency: divider[v] applied while en[v]=0 is visible as the active period on the first enabled cycle.
- Voices are fully independent; simultaneous wraps on any subset of voices are legal.

Optional Feature:
- Macro: OSC_BANK_SYNC_EN.
- Defined: adds two ports.
  - sync  in  1  global hard-sync strobe.
  - sync_mask  in  VOICES  voices that follow sync.
- While sync is high, each enabled voice with its mask bit set behaves exactly as at a wrap:
  - count = 1; wrap = 1;
  - active_div reloaded.
- Priority order: rst > en = 0 > sync > normal counting.
- Undefined: ports absent; behaviour exactly as above.

Decomposition:
- Package osc_bank_pkg holds:
  - the default constants OSC_WIDTH = 16 and OSC_VOICES = 4;
  - a function returning the square threshold (div >> 1).
- One sub-module, osc_voice, is natural:
  - a single WIDTH-parameterised voice (count, active_div, wrap, square);
  - osc_bank instantiates VOICES copies in a generate loop and handles port packing and the sync fan-out.

Test Plan:
- Reset and enable:
  - Stimulus: rst high 2 cycles, then release; en=0.
  - Required: all count = 1, wrap = 0, square = 0.
  - Stimulus: then en[0]=1 with divider[0]=4.
  - Required: count[0] = 1,2,3,4,1,2...; wrap[0] high every 4th cycle, coincident with count=1; square[0] high while count <= 2.
- Degenerate dividers:
  - Stimulus: divider[1] = 0, then 1, with en[1]=1.
  - Required: count[1] stays 1; wrap[1] high every cycle.
- Glitch-free update:
  - Stimulus: voice 0 running at D=8; change divider to 3 when count=2.
  - Required: count continues 3..8; then wrap; then period 3 (1,2,3,1).
- Independence:
  - Stimulus: dividers 2, 3, 5, 7 on voices 0-3, all enabled.
  - Required: each wrap has its own period; all four wrap together at cycle 210 after enable; no cross-coupling.
- Reset mid-operation:
  - Stimulus: rst pulsed while count[2] = 5 of D = 9.
  - Required: next cycle count[2] = 1, wrap[2] = 0, active_div = 0; resumes with the current divider after release.
- OSC_BANK_SYNC_EN:
  - Stimulus: sync pulse with sync_mask = 4'b0101, voices at D = 6.
  - Required: voices 0 and 2 restart at 1 with wrap; voices 1 and 3 unaffected.

Source files
------------

// File: rtl/osc_bank_pkg.sv
// osc_bank_pkg: default bank dimensions and the square-wave threshold helper shared by osc_bank and osc_voice
package osc_bank_pkg;
  localparam int OSC_WIDTH = 16;
  localparam int OSC_VOICES = 4;
  function automatic logic [31:0] sq_thresh(input logic [31:0] div);
    return div >> 1;
  endfunction
endpackage

// File: rtl/osc_voice.sv
// osc_voice: one divider oscillator voice; ports clk, rst, en, sync (hard restart), divider in, count/wrap/square out
module osc_voice
  import osc_bank_pkg::*;
#(
  parameter int WIDTH = OSC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [WIDTH-1:0] divider,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             square
);
  logic [WIDTH-1:0] r_count, r_div;
  logic             r_wrap;
  logic             w_restart;
  assign w_restart = sync || (r_count >= r_div);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= WIDTH'(1);
      r_div   <= '0;
      r_wrap  <= 1'b0;
    end else if (!en) begin
      r_count <= WIDTH'(1);
      r_div   <= divider;
      r_wrap  <= 1'b0;
    end else if (w_restart) begin
      r_count <= WIDTH'(1);
      r_div   <= divider;
      r_wrap  <= 1'b1;
    end else begin
      r_count <= r_count + WIDTH'(1);
      r_wrap  <= 1'b0;
    end
  end
  assign count  = r_count;
  assign wrap   = r_wrap;
  assign square = en && (r_count <= WIDTH'(sq_thresh(32'(r_div))));
endmodule

// File: rtl/osc_bank.sv
// osc_bank: VOICES-voice divider oscillator bank; ports clk, rst, en, divider, count, wrap, square (+sync, sync_mask when OSC_BANK_SYNC_EN)
module osc_bank
  import osc_bank_pkg::*;
#(
  parameter int WIDTH  = OSC_WIDTH,
  parameter int VOICES = OSC_VOICES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VOICES-1:0]       en,
  input  logic [VOICES*WIDTH-1:0] divider,
`ifdef OSC_BANK_SYNC_EN
  input  logic                    sync,
  input  logic [VOICES-1:0]       sync_mask,
`endif
  output logic [VOICES*WIDTH-1:0] count,
  output logic [VOICES-1:0]       wrap,
  output logic [VOICES-1:0]       square
);
  logic [VOICES-1:0] w_sync;
`ifdef OSC_BANK_SYNC_EN
  assign w_sync = sync_mask & {VOICES{sync}};
`else
  assign w_sync = '0;
`endif
  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    osc_voice #(.WIDTH(WIDTH)) u_voice (
      .clk    (clk),
      .rst    (rst),
      .en     (en[v]),
      .sync   (w_sync[v]),
      .divider(divider[v*WIDTH +: WIDTH]),
      .count  (count[v*WIDTH +: WIDTH]),
      .wrap   (wrap[v]),
      .square (square[v])
    );
  end
endmodule

// File: tb/tb_osc_bank.sv
// tb_osc_bank: self-checking bench for osc_bank (default build) with vector table, corner sequences and random model comparison
module tb_osc_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic [63:0] divider;
  logic [63:0] count;
  logic [3:0]  wrap, square;
  int n_cmp = 0, n_fail = 0;
  int mc[4], ma[4];
  bit mw[4];
  typedef struct {
    bit         r;
    logic [3:0] e;
    int         d0;
    int         c0;
    bit         w0;
    bit         s0;
  } vec_t;
  vec_t tbl[10];
  always #5 clk = ~clk;
  osc_bank dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .divider(divider),
    .count  (count),
    .wrap   (wrap),
    .square (square)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int dv(input int v);
    return int'(divider[v*16 +: 16]);
  endfunction
  task automatic tick();
    @(posedge clk);
    for (int v = 0; v < 4; v++) begin
      if (rst) begin
        mc[v] = 1; ma[v] = 0; mw[v] = 0;
      end else if (!en[v]) begin
        mc[v] = 1; ma[v] = dv(v); mw[v] = 0;
      end else if (mc[v] >= ma[v]) begin
        mc[v] = 1; ma[v] = dv(v); mw[v] = 1;
      end else begin
        mc[v] = mc[v] + 1; mw[v] = 0;
      end
    end
    #1;
    for (int v = 0; v < 4; v++) begin
      chk($sformatf("model_count[%0d]", v), 32'(count[v*16 +: 16]), 32'(mc[v]));
      chk($sformatf("model_wrap[%0d]", v), 32'(wrap[v]), 32'(mw[v]));
      chk($sformatf("model_square[%0d]", v), 32'(square[v]), 32'(en[v] && (mc[v] <= ma[v] / 2)));
    end
  endtask
  task automatic do_reset();
    rst = 1'b1; en = '0; divider = '0;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    int ge[13] = '{3, 4, 5, 6, 7, 8, 1, 2, 3, 1, 2, 3, 1};
    int dd[4] = '{2, 3, 5, 7};
    int nall;
    rst = 1'b1; en = '0; divider = '0;
    tbl[0] = '{1, 4'b0000, 4, 1, 0, 0};
    tbl[1] = '{1, 4'b0000, 4, 1, 0, 0};
    tbl[2] = '{0, 4'b0000, 4, 1, 0, 0};
    tbl[3] = '{0, 4'b0001, 4, 2, 0, 1};
    tbl[4] = '{0, 4'b0001, 4, 3, 0, 0};
    tbl[5] = '{0, 4'b0001, 4, 4, 0, 0};
    tbl[6] = '{0, 4'b0001, 4, 1, 1, 1};
    tbl[7] = '{0, 4'b0001, 4, 2, 0, 1};
    tbl[8] = '{0, 4'b0001, 4, 3, 0, 0};
    tbl[9] = '{0, 4'b0001, 4, 4, 0, 0};
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].r; en = tbl[i].e; divider = '0; divider[15:0] = 16'(tbl[i].d0);
      tick();
      chk($sformatf("tbl%0d_count0", i), 32'(count[15:0]), 32'(tbl[i].c0));
      chk($sformatf("tbl%0d_wrap0", i), 32'(wrap[0]), 32'(tbl[i].w0));
      chk($sformatf("tbl%0d_square0", i), 32'(square[0]), 32'(tbl[i].s0));
      if (i < 2) chk($sformatf("tbl%0d_rst_all", i), {count, wrap, square}, {16'd1, 16'd1, 16'd1, 16'd1, 8'd0});
    end
    do_reset();
    for (int ph = 0; ph < 2; ph++) begin
      divider[31:16] = 16'(ph);
      if (ph == 0) tick();
      en = 4'b0010;
      for (int k = 0; k < 4; k++) begin
        tick();
        chk($sformatf("degen%0d_count1", ph), 32'(count[31:16]), 32'd1);
        chk($sformatf("degen%0d_wrap1", ph), 32'(wrap[1]), 32'd1);
      end
    end
    do_reset();
    divider[15:0] = 16'd8;
    tick();
    en = 4'b0001;
    tick();
    chk("glitch_start_count0", 32'(count[15:0]), 32'd2);
    divider[15:0] = 16'd3;
    for (int k = 0; k < 13; k++) begin
      tick();
      chk($sformatf("glitch%0d_count0", k), 32'(count[15:0]), 32'(ge[k]));
      chk($sformatf("glitch%0d_wrap0", k), 32'(wrap[0]), 32'(ge[k] == 1));
    end
    do_reset();
    for (int v = 0; v < 4; v++) divider[v*16 +: 16] = 16'(dd[v]);
    tick();
    en = 4'hf;
    nall = 0;
    for (int k = 1; k <= 210; k++) begin
      tick();
      for (int v = 0; v < 4; v++) begin
        chk($sformatf("indep_k%0d_wrap%0d", k, v), 32'(wrap[v]), 32'(k % dd[v] == 0));
        chk($sformatf("indep_k%0d_count%0d", k, v), 32'(count[v*16 +: 16]), 32'(k % dd[v] + 1));
      end
      if (&wrap) nall++;
    end
    chk("indep_all_wrap_210", 32'(wrap), 32'hf);
    chk("indep_all_wrap_once", 32'(nall), 32'd1);
    do_reset();
    divider[47:32] = 16'd9;
    tick();
    en = 4'b0100;
    for (int k = 0; k < 4; k++) tick();
    chk("rstmid_pre_count2", 32'(count[47:32]), 32'd5);
    rst = 1'b1;
    tick();
    chk("rstmid_count2", 32'(count[47:32]), 32'd1);
    chk("rstmid_wrap2", 32'(wrap[2]), 32'd0);
    rst = 1'b0;
    tick();
    chk("rstmid_resume_count2", 32'(count[47:32]), 32'd1);
    chk("rstmid_resume_wrap2", 32'(wrap[2]), 32'd1);
    for (int k = 2; k <= 9; k++) begin
      tick();
      chk($sformatf("rstmid_run%0d_count2", k), 32'(count[47:32]), 32'(k));
    end
    tick();
    chk("rstmid_rewrap2", 32'(wrap[2]), 32'd1);
    do_reset();
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) en = 4'($urandom);
      for (int v = 0; v < 4; v++) divider[v*16 +: 16] = 16'($urandom_range(0, 12));
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
